// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, frame constants and the host-to-device frame builder.
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t IDLE      = 3'd0;
  localparam ps2_state_t INHIBIT   = 3'd1;
  localparam ps2_state_t REQ       = 3'd2;
  localparam ps2_state_t ACK       = 3'd3;
  localparam ps2_state_t WAIT_IDLE = 3'd4;

  localparam int         PS2_FRAME_BITS  = 11;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // Bits shifted out after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the PS/2 clock and data lines plus a falling-edge strobe on the clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_async,
  input  logic i_data_async,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall
);

  logic [2:0] r_clk_sh;
  logic [1:0] r_data_sh;

  // Idle PS/2 lines float high, so the chains reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sh  <= '1;
      r_data_sh <= '1;
    end else begin
      r_clk_sh  <= {r_clk_sh[1:0], i_clk_async};
      r_data_sh <= {r_data_sh[0], i_data_async};
    end
  end

  assign o_clk_sync  = r_clk_sh[1];
  assign o_data_sync = r_data_sh[1];
  assign o_clk_fall  = r_clk_sh[2] & ~r_clk_sh[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables on ps2_clk/ps2_data.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_FALL = 4'(PS2_FRAME_BITS - 2);

  ps2_state_t       r_state;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [3:0]       r_bit_cnt;
  logic [9:0]       r_shreg;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_done;
  logic             r_ack_err;
  logic             r_timeout;
  logic             r_ack_ok;

  logic w_clk_sync;
  logic w_data_sync;
  logic w_fall;
  logic w_accept;
  logic w_to_hit;

  ps2_sync_edge u_sync (
    .clk          (clk),
    .rst          (rst),
    .i_clk_async  (ps2_clk_in),
    .i_data_async (ps2_data_in),
    .o_clk_sync   (w_clk_sync),
    .o_data_sync  (w_data_sync),
    .o_clk_fall   (w_fall)
  );

  assign w_accept = tx_valid && (r_state == IDLE);
  assign w_to_hit = (r_to_cnt == TO_LAST);

  // Frame shifter carries payload only; it is always loaded before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shreg <= ps2_tx_frame(tx_data);
    end else if (w_fall && (r_state == REQ)) begin
      r_shreg <= {1'b1, r_shreg[9:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bit_cnt <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;
      r_ack_ok  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;

      // The watchdog only runs once the device owns the clock.
      if (w_fall || (r_state == IDLE) || (r_state == INHIBIT)) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= INHIBIT;
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
            r_inh_cnt <= '0;
            r_bit_cnt <= '0;
            r_ack_ok  <= 1'b0;
          end
        end
        INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            r_state   <= REQ;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b1;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end
        REQ: begin
          if (w_fall) begin
            r_data_oe <= ~r_shreg[0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_FALL) begin
              r_state <= ACK;
            end
          end else if (w_to_hit) begin
            r_state   <= IDLE;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        ACK: begin
          if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_state   <= WAIT_IDLE;
            r_ack_err <= w_data_sync;
            r_ack_ok  <= ~w_data_sync;
          end else if (w_to_hit) begin
            r_state   <= IDLE;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        WAIT_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (w_clk_sync && w_data_sync) begin
            r_state <= IDLE;
            r_done  <= r_ack_ok;
          end else if (w_to_hit) begin
            // An already-reported ack_err keeps the outcome pulses exclusive.
            r_state   <= IDLE;
            r_timeout <= r_ack_ok;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready    = (r_state == IDLE);
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign ack_err     = r_ack_err;
  assign timeout     = r_timeout;

endmodule
